// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch stage.
// Contains the default bus widths, the reset PC, the fetch FSM state encodings
// and a helper that sizes the memory wait counter.
package fetch_unit_pkg;

  localparam int unsigned FU_ADDR_W   = 16;
  localparam int unsigned FU_DATA_W   = 16;
  localparam int unsigned FU_RESET_PC = 0;

  typedef logic [0:0] fstate_t;

  localparam fstate_t FS_IDLE = 1'b0;
  localparam fstate_t FS_REQ  = 1'b1;

  // Wait counter width: $clog2(TIMEOUT), with a floor of one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control, memory and decode-side signals of the fetch stage.
//   master : view of the fetch unit (drives mem_req/mem_addr and decode outputs)
//   slave  : view of the environment (controller, writeback, memory, decode)
// ADDR_W / DATA_W must match the parameters of the attached fetch_unit.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = fetch_unit_pkg::FU_ADDR_W,
  parameter int unsigned DATA_W = fetch_unit_pkg::FU_DATA_W
);
  logic              fetch_en;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fault;

  modport master (
    input  fetch_en, pc_load, pc_load_addr, mem_ready, mem_rdata,
    output mem_req, mem_addr, instr, instr_pc, instr_valid, pc, busy, fault
  );

  modport slave (
    output fetch_en, pc_load, pc_load_addr, mem_ready, mem_rdata,
    input  mem_req, mem_addr, instr, instr_pc, instr_valid, pc, busy, fault
  );
endinterface

// File: rtl/fetch_unit_rise_detect.sv
// rise_detect: 1-bit rising-edge detector on a synchronous level.
//   clk    : clock
//   rst    : asynchronous active-low reset
//   d_i    : level input, sampled on the rising edge
//   rise_o : d_i high now and low at the previous edge (combinational from d_i)
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Each rising edge of the fetch phase level issues one memory read at pc,
// latches the returned word for decode and advances pc. Writeback redirects
// overwrite pc (deferred until completion when a read is in flight). A read
// that sees no mem_ready for TIMEOUT edges raises a sticky fault.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-low reset
//   bus : fetch_unit_if master view (fetch_en, pc_load*, mem_*, instr*, pc,
//         busy, fault)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = FU_ADDR_W,
  parameter int unsigned DATA_W   = FU_DATA_W,
  parameter int unsigned RESET_PC = FU_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(TIMEOUT - 1);

  fstate_t           state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic              start;
  logic              redir_any;
  logic [ADDR_W-1:0] redir_addr;

  rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.fetch_en),
    .rise_o (start)
  );

  // Redirect seen while in REQ: a strobe on this very edge beats an older
  // pending target, so the newest writeback target always wins.
  assign redir_any  = bus.pc_load | pend_q;
  assign redir_addr = bus.pc_load ? bus.pc_load_addr : pend_addr_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    mem_req_d     = mem_req_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    wait_d        = wait_q;
    pend_d        = pend_q;
    pend_addr_d   = pend_addr_q;

    unique case (state_q)
      FS_IDLE: begin
        if (bus.pc_load) pc_d = bus.pc_load_addr;
        if (start && !fault_q) begin
          state_d       = FS_REQ;
          mem_req_d     = 1'b1;
          mem_addr_d    = bus.pc_load ? bus.pc_load_addr : pc_q;
          instr_valid_d = 1'b0;
          wait_d        = '0;
          pend_d        = 1'b0;
        end
      end
      FS_REQ: begin
        if (bus.pc_load) begin
          pend_d      = 1'b1;
          pend_addr_d = bus.pc_load_addr;
        end
        if (bus.mem_ready) begin
          state_d       = FS_IDLE;
          mem_req_d     = 1'b0;
          instr_d       = bus.mem_rdata;
          instr_pc_d    = mem_addr_q;
          instr_valid_d = 1'b1;
          pc_d          = redir_any ? redir_addr : mem_addr_q + ADDR_W'(1);
          pend_d        = 1'b0;
        end else if (wait_q == CNT_END) begin
          state_d       = FS_IDLE;
          mem_req_d     = 1'b0;
          instr_valid_d = 1'b0;
          fault_d       = 1'b1;
          if (redir_any) pc_d = redir_addr;
          pend_d        = 1'b0;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FS_IDLE;
      pc_q          <= PC_RST;
      mem_addr_q    <= PC_RST;
      mem_req_q     <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      wait_q        <= '0;
      pend_q        <= 1'b0;
      pend_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      wait_q        <= wait_d;
      pend_q        <= pend_d;
      pend_addr_q   <= pend_addr_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q == FS_REQ);
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   req_cnt;
  int   done_cnt;
  logic prev_valid;

  fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (0),
    .TIMEOUT  (16)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(bus.mem_req), 32'h0);
    chk({tag, "_addr"},  32'(bus.mem_addr), 32'h0);
    chk({tag, "_pc"},    32'(bus.pc), 32'h0);
    chk({tag, "_instr"}, 32'(bus.instr), 32'h0);
    chk({tag, "_ipc"},   32'(bus.instr_pc), 32'h0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
    chk({tag, "_busy"},  32'(bus.busy), 32'h0);
    chk({tag, "_fault"}, 32'(bus.fault), 32'h0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    bus.fetch_en     = 1'b0;
    bus.pc_load      = 1'b0;
    bus.pc_load_addr = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-REQ, released with fetch_en low.
    bus.fetch_en = 1'b1;
    tick();
    chk("pre_rst_busy", 32'(bus.busy), 32'h1);
    bus.fetch_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst_rel");

    // Zero-wait fetch returning A5C3.
    bus.fetch_en = 1'b1;
    tick();
    chk("zw_req", 32'(bus.mem_req), 32'h1);
    chk("zw_addr", 32'(bus.mem_addr), 32'h0000);
    bus.fetch_en  = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hA5C3;
    tick();
    bus.mem_ready = 1'b0;
    chk("zw_req_off", 32'(bus.mem_req), 32'h0);
    chk("zw_instr", 32'(bus.instr), 32'hA5C3);
    chk("zw_ipc", 32'(bus.instr_pc), 32'h0000);
    chk("zw_valid", 32'(bus.instr_valid), 32'h1);
    chk("zw_pc", 32'(bus.pc), 32'h0001);
    tick();

    // Redirect to FFFF in IDLE, then two 3-wait fetches across the wrap.
    bus.pc_load      = 1'b1;
    bus.pc_load_addr = 16'hFFFF;
    tick();
    bus.pc_load = 1'b0;
    chk("ld_pc", 32'(bus.pc), 32'hFFFF);
    for (int f = 0; f < 2; f++) begin
      bus.fetch_en = 1'b1;
      tick();
      bus.fetch_en = 1'b0;
      chk("wr_addr", 32'(bus.mem_addr), (f == 0) ? 32'hFFFF : 32'h0000);
      chk("wr_valid_clr", 32'(bus.instr_valid), 32'h0);
      for (int w = 0; w < 3; w++) begin
        tick();
        chk("wr_wait_req", 32'(bus.mem_req), 32'h1);
        chk("wr_wait_valid", 32'(bus.instr_valid), 32'h0);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = (f == 0) ? 16'h1111 : 16'h2222;
      tick();
      bus.mem_ready = 1'b0;
      chk("wr_valid", 32'(bus.instr_valid), 32'h1);
      chk("wr_instr", 32'(bus.instr), (f == 0) ? 32'h1111 : 32'h2222);
      chk("wr_pc", 32'(bus.pc), (f == 0) ? 32'h0000 : 32'h0001);
      tick();
    end

    // Redirect to 1234 during a read at 0005.
    bus.pc_load      = 1'b1;
    bus.pc_load_addr = 16'h0005;
    tick();
    bus.pc_load  = 1'b0;
    bus.fetch_en = 1'b1;
    tick();
    bus.fetch_en = 1'b0;
    chk("rd_addr", 32'(bus.mem_addr), 32'h0005);
    bus.pc_load      = 1'b1;
    bus.pc_load_addr = 16'h1234;
    tick();
    bus.pc_load = 1'b0;
    chk("rd_addr_hold", 32'(bus.mem_addr), 32'h0005);
    chk("rd_pc_hold", 32'(bus.pc), 32'h0005);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick();
    bus.mem_ready = 1'b0;
    chk("rd_ipc", 32'(bus.instr_pc), 32'h0005);
    chk("rd_pc", 32'(bus.pc), 32'h1234);
    tick();
    bus.fetch_en = 1'b1;
    tick();
    bus.fetch_en = 1'b0;
    chk("rd_next_addr", 32'(bus.mem_addr), 32'h1234);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("rd_next_pc", 32'(bus.pc), 32'h1235);
    tick();

    // fetch_en held high for 10 cycles with a ready memory: one request only.
    req_cnt    = 0;
    done_cnt   = 0;
    prev_valid = bus.instr_valid;
    bus.fetch_en  = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mem_req) req_cnt++;
      if (bus.instr_valid && !prev_valid) done_cnt++;
      prev_valid = bus.instr_valid;
    end
    bus.fetch_en  = 1'b0;
    bus.mem_ready = 1'b0;
    chk("hold_reqs", 32'(req_cnt), 32'd1);
    chk("hold_done", 32'(done_cnt), 32'd1);
    chk("hold_pc", 32'(bus.pc), 32'h1236);
    tick();

    // Second fetch_en pulse during REQ is ignored.
    req_cnt  = 0;
    done_cnt = 0;
    prev_valid = bus.instr_valid;
    for (int i = 0; i < 9; i++) begin
      bus.fetch_en  = (i == 0 || i == 2);
      bus.mem_ready = (i == 4);
      tick();
      if (bus.mem_req) req_cnt++;
      if (bus.instr_valid && !prev_valid) done_cnt++;
      prev_valid = bus.instr_valid;
    end
    bus.fetch_en  = 1'b0;
    bus.mem_ready = 1'b0;
    chk("dbl_reqs", 32'(req_cnt), 32'd4);
    chk("dbl_done", 32'(done_cnt), 32'd1);
    chk("dbl_pc", 32'(bus.pc), 32'h1237);

    // Timeout: memory never ready.
    req_cnt = 0;
    bus.fetch_en = 1'b1;
    tick();
    bus.fetch_en = 1'b0;
    if (bus.mem_req) req_cnt++;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.mem_req) req_cnt++;
    end
    chk("to_reqs", 32'(req_cnt), 32'd16);
    chk("to_fault", 32'(bus.fault), 32'h1);
    chk("to_valid", 32'(bus.instr_valid), 32'h0);
    chk("to_pc", 32'(bus.pc), 32'h1237);
    for (int p = 0; p < 3; p++) begin
      bus.fetch_en = 1'b1;
      tick();
      chk("flt_no_req", 32'(bus.mem_req), 32'h0);
      bus.fetch_en = 1'b0;
      tick();
      chk("flt_no_req2", 32'(bus.mem_req), 32'h0);
    end
    bus.pc_load      = 1'b1;
    bus.pc_load_addr = 16'h0042;
    tick();
    bus.pc_load = 1'b0;
    chk("flt_pc_load", 32'(bus.pc), 32'h0042);
    chk("flt_sticky", 32'(bus.fault), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("flt_rst_clr", 32'(bus.fault), 32'h0);
    chk("flt_rst_pc", 32'(bus.pc), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage, directly downstream of `control_fsm`. Each fetch phase from the controller starts one read from instruction memory at the current PC, latches the returned word for the decode stage and advances the PC. A redirect from writeback can overwrite the PC. A timeout raises a sticky fault if memory never answers.

## Interface
- `ADDR_W`, 16, PC / memory address width
- `DATA_W`, 16, instruction word width
- `RESET_PC`, 0, PC value after reset
- `TIMEOUT`, 16, maximum `REQ` edges without `mem_ready` before fault (≥2)

- `clk` input 1: single clock; all state changes on the rising edge
- `rst` input 1: asynchronous, active-low reset
- `fetch_en` input 1: fetch phase level (`fetch_clk` from `control_fsm`); sampled synchronously
- `pc_load` input 1: redirect strobe from writeback
- `pc_load_addr` input ADDR_W: redirect target
- `mem_req` output 1: read request, registered
- `mem_addr` output ADDR_W: read address, registered, stable while `mem_req`=1
- `mem_ready` input 1: `mem_rdata` valid this edge; ignored when `mem_req`=0
- `mem_rdata` input DATA_W: instruction word
- `instr` output DATA_W: last fetched word
- `instr_pc` output ADDR_W: address `instr` came from
- `instr_valid` output 1: `instr` / `instr_pc` valid for decode
- `pc` output ADDR_W: next fetch address
- `busy` output 1: high in `REQ`
- `fault` output 1: sticky memory-timeout flag

## Operation
- Reset (async assert, sync release): `state`=`IDLE`, `pc`=`RESET_PC`, `mem_addr`=`RESET_PC`, `mem_req`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `busy`=0, `fault`=0, `wait_cnt`=0, `fetch_en_q`=0, redirect pending flag=0.
- Start condition is `fetch_en`=1 and `fetch_en_q`=0, where `fetch_en_q` is `fetch_en` delayed one edge.
- `IDLE`:
  - Start with `fault`=0 → `REQ`, `mem_req`=1, `mem_addr`=`pc`, `instr_valid`=0, `wait_cnt`=0.
  - `pc_load` → `pc`=`pc_load_addr`.
  - Start and `pc_load` on the same edge → `pc` and `mem_addr` both = `pc_load_addr`.
- `REQ`:
  - `mem_ready`=1 → `instr`=`mem_rdata`, `instr_pc`=`mem_addr`, `instr_valid`=1, `mem_req`=0, go to `IDLE`.
  - On that same completion, `pc`=pending redirect target if one is pending, else `mem_addr`+1 (modulo 2^ADDR_W, FFFF→0000). The pending flag clears.
  - `pc_load` in `REQ` latches the target as pending; a later `pc_load` overwrites it. `mem_addr` is unchanged.
  - No ready and `wait_cnt`=TIMEOUT−1 → `fault`=1, `mem_req`=0, `instr_valid`=0, go to `IDLE`. `pc` is unchanged; a pending redirect is applied to `pc`.
  - Otherwise `wait_cnt`+1.
  - A start condition in `REQ` is ignored (no queueing).
- `instr_valid` holds from completion until the next accepted start.
- `fault` clears only on reset. While `fault`=1, starts are ignored but `pc_load` still updates `pc`.
- `busy` = (`state`==`REQ`).

## Timing
- Start sampled at edge n → `mem_req`=1 after edge n.
- First `mem_ready` sample is at edge n+1. Zero-wait memory gives `instr_valid`=1 and updated `pc` after edge n+1, i.e. 2 edges from start.
- Each wait cycle adds 1.
- Timeout: `mem_req` high for exactly TIMEOUT edges, then `fault` rises after edge n+TIMEOUT.
- `control_fsm` gives the fetch phase ≥2 clocks before decode. Zero-wait memory therefore meets decode.

## Structure
- Shared header `luna_defs.vh` holds:
  - state encodings `FS_IDLE` and `FS_REQ`,
  - default `ADDR_W` / `DATA_W`,
  - `RESET_PC`.
- `wait_cnt` width is `$clog2(TIMEOUT)`.
- Sub-module `rise_detect` (1-bit registered rising-edge detector, `clk`/`rst`) produces the start condition. It is reusable by decode/exec/writeback consumers of `control_fsm`.

## Test plan
- Reset mid-`REQ`, then release with `fetch_en`=0 → all outputs at reset values, `pc`=0000, no `mem_req`.
- Start, `mem_ready` on first sample, `mem_rdata`=A5C3:
  - `mem_req` high for 1 cycle, `mem_addr`=0000.
  - Then `instr`=A5C3, `instr_pc`=0000, `instr_valid`=1, `pc`=0001.
- `pc_load`=1 with `pc_load_addr`=FFFF in `IDLE`, then two fetches with 3 wait cycles each:
  - `mem_addr` FFFF then 0000; `pc` wraps to 0000 then 0001.
  - `instr_valid` rises 5 edges after each start.
- `pc_load_addr`=1234 pulsed during `REQ` at addr 0005 → `instr_pc`=0005, `pc`=1234, next `mem_addr`=1234.
- `mem_ready` held 0, TIMEOUT=16 → `mem_req` high exactly 16 edges, then `fault`=1.
  - Further `fetch_en` pulses produce no `mem_req`.
  - `fault` stays 1 until reset.
- `fetch_en` held high 10 cycles → exactly one request.
- `fetch_en` pulsed again during `REQ` → ignored; one completion only.
